// File: rtl/axi4lite_cmd_master.sv
// axi4lite_cmd_master
// -------------------
// AXI4-Lite bus initiator for register access. Accepts one read or write
// command on a valid/ready command port, runs exactly one AXI4-Lite
// transaction on the five channels, and returns read data plus the response
// code on a valid/ready response port. Only one transaction is in flight.
//
// Handshake rule used on every channel in this file: a transfer happens on a
// rising edge where VALID and READY are both 1. A VALID driven by this block
// never drops before its transfer and clears on the edge of its own transfer.
// Payload driven by this block is held constant while its VALID is high.
//
// Ports
//   A_CLK, A_RST          clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is 1 only in IDLE
//   cmd_write, cmd_addr, cmd_wdata, cmd_wstrb   command payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_write, rsp_rdata, rsp_resp              response payload
//   AW_*, W_*, B_*, AR_*, R_*                   AXI4-Lite master channels
//   dbg_state             current FSM state encoding (debug / checker bind)
module axi4lite_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  A_CLK,
  input  logic                  A_RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [ADDR_W-1:0]     AW_ADDR,
  output logic [2:0]            AW_PROT,
  output logic                  W_VALID,
  input  logic                  W_READY,
  output logic [DATA_W-1:0]     W_DATA,
  output logic [DATA_W/8-1:0]   W_STRB,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [1:0]            B_RESP,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [ADDR_W-1:0]     AR_ADDR,
  output logic [2:0]            AR_PROT,
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [DATA_W-1:0]     R_DATA,
  input  logic [1:0]            R_RESP,
  output logic [2:0]            dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RSP          = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
  logic                aw_valid_q,  aw_valid_d;
  logic                w_valid_q,   w_valid_d;
  logic                aw_done_q,   aw_done_d;
  logic                w_done_q,    w_done_d;
  logic                b_ready_q,   b_ready_d;
  logic                ar_valid_q,  ar_valid_d;
  logic                r_ready_q,   r_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q,  rsp_resp_d;

  // Held low while reset is asserted so no command is taken in that cycle,
  // regardless of what state the flops held before reset.
  assign cmd_ready = (state_q == S_IDLE) && !A_RST;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = S_WR_ADDR_DATA;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = S_RD_ADDR;
          end
        end
      end

      S_WR_ADDR_DATA: begin
        // AW and W finish independently; the done flags remember which one
        // has already transferred so the other can keep waiting.
        if (aw_valid_q && AW_READY) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && W_READY) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        // Using the next-state flags covers both transfers landing together.
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (B_VALID && b_ready_q) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = B_RESP;
          state_d     = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (ar_valid_q && AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (R_VALID && r_ready_q) begin
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = R_DATA;
          rsp_resp_d  = R_RESP;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        b_ready_d   = 1'b0;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // The latched command drives both address channels; only the channel whose
  // VALID is high carries meaning.
  assign AW_VALID  = aw_valid_q;
  assign AW_ADDR   = addr_q;
  assign AW_PROT   = 3'b000;
  assign W_VALID   = w_valid_q;
  assign W_DATA    = wdata_q;
  assign W_STRB    = wstrb_q;
  assign B_READY   = b_ready_q;
  assign AR_VALID  = ar_valid_q;
  assign AR_ADDR   = addr_q;
  assign AR_PROT   = 3'b000;
  assign R_READY   = r_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed plus short random bench for axi4lite_cmd_master. The bench plays
// the AXI4-Lite slave and the command/response endpoints cycle by cycle.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_axi4lite_cmd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SB_W   = 1 + 2 + DATA_W;

  logic                A_CLK = 1'b0;
  logic                A_RST;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;
  logic                rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic                AW_VALID, AW_READY;
  logic [ADDR_W-1:0]   AW_ADDR;
  logic [2:0]          AW_PROT;
  logic                W_VALID, W_READY;
  logic [DATA_W-1:0]   W_DATA;
  logic [DATA_W/8-1:0] W_STRB;
  logic                B_VALID, B_READY;
  logic [1:0]          B_RESP;
  logic                AR_VALID, AR_READY;
  logic [ADDR_W-1:0]   AR_ADDR;
  logic [2:0]          AR_PROT;
  logic                R_VALID, R_READY;
  logic [DATA_W-1:0]   R_DATA;
  logic [1:0]          R_RESP;
  logic [2:0]          dbg_state;

  axi4lite_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 A_CLK = ~A_CLK;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the response on its handshake cycle with the oldest
  // expected entry.
  task automatic sb_check(input string tag);
    logic [SB_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s observed=response expected=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, e});
    end
  endtask

  task automatic push_exp(input logic wr, input logic [1:0] resp, input logic [DATA_W-1:0] rdata);
    exp_q.push_back({wr, resp, rdata});
  endtask

  task automatic slave_idle();
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
  endtask

  task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
  endtask

  initial begin
    logic              wr;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd, wd;
    logic [1:0]        rr;
    bit                done;

    A_RST = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0;
    slave_idle();

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, rsp_valid}, 0);
    chk("rst_payload", {AW_ADDR, W_DATA}, 0);
    chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata, W_STRB, AW_PROT, AR_PROT}, 0);
    A_RST = 0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // 1: write, always-ready slave, minimum latency
    AW_READY = 1; W_READY = 1;
    drive_cmd(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    push_exp(1, 2'b00, 0);
    tick();                                       // cycle 1
    cmd_valid = 0;
    chk("t1_awv_wv", {AW_VALID, W_VALID, B_READY}, 3'b110);
    chk("t1_aw_addr", AW_ADDR, 32'h0000_0010);
    chk("t1_w_data", {W_DATA, W_STRB}, {32'hDEAD_BEEF, 4'hF});
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    tick();                                       // cycle 2
    chk("t1_b_ready", {AW_VALID, W_VALID, B_READY}, 3'b001);
    B_VALID = 1; B_RESP = 2'b00;
    tick();                                       // cycle 3
    B_VALID = 0;
    chk("t1_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    sb_check("t1_rsp");
    tick();
    rsp_ready = 0;
    chk("t1_rsp_done", {rsp_valid, cmd_ready}, 2'b01);

    // 2: read with AR_READY low for 3 cycles
    slave_idle();
    drive_cmd(0, 32'h0000_0020, 32'h0, 4'h0);
    push_exp(0, 2'b00, 32'h1234_5678);
    tick();
    cmd_valid = 0;
    chk("t2_r_ready_early", {R_READY, AW_VALID, W_VALID}, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_ar_hold", {AR_VALID, AR_ADDR}, {1'b1, 32'h0000_0020});
      if (i == 4) AR_READY = 1;
      tick();
    end
    AR_READY = 0;
    chk("t2_r_ready", {AR_VALID, R_READY}, 2'b01);
    R_VALID = 1; R_DATA = 32'h1234_5678; R_RESP = 2'b00;
    tick();
    R_VALID = 0;
    chk("t2_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    sb_check("t2_rsp");
    tick();
    rsp_ready = 0;

    // 3: W accepted at cycle 1, AW at cycle 4
    slave_idle();
    drive_cmd(1, 32'h0000_0abc, 32'h0bad_cafe, 4'h5);
    push_exp(1, 2'b01, 0);
    tick();                                       // cycle 1
    cmd_valid = 0;
    chk("t3_c1", {AW_VALID, W_VALID}, 2'b11);
    W_READY = 1;
    tick();                                       // cycle 2
    W_READY = 0;
    chk("t3_c2", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();                                       // cycle 3
    chk("t3_c3", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();                                       // cycle 4
    chk("t3_c4", {AW_VALID, W_VALID, B_READY, AW_ADDR}, {3'b100, 32'h0000_0abc});
    AW_READY = 1;
    tick();                                       // cycle 5
    AW_READY = 0;
    chk("t3_c5", {AW_VALID, W_VALID, B_READY}, 3'b001);
    B_VALID = 1; B_RESP = 2'b01;
    tick();
    B_VALID = 0;
    rsp_ready = 1;
    chk("t3_rsp_valid", rsp_valid, 1);
    sb_check("t3_rsp");
    tick();
    rsp_ready = 0;

    // 4: read with SLVERR, response backpressure for 5 cycles
    slave_idle();
    AR_READY = 1;
    drive_cmd(0, 32'h0000_0044, 32'h0, 4'h0);
    push_exp(0, 2'b10, 32'hCAFE_F00D);
    tick();                                       // cycle 1: AR handshake
    cmd_valid = 0;
    tick();                                       // cycle 2: R handshake
    AR_READY = 0;
    R_VALID = 1; R_DATA = 32'hCAFE_F00D; R_RESP = 2'b10;
    tick();                                       // cycle 3: response
    R_VALID = 0; R_DATA = 32'h0;
    for (int i = 0; i < 6; i++) begin
      chk("t4_rsp_hold", {rsp_valid, cmd_ready, rsp_resp, rsp_rdata},
          {1'b1, 1'b0, 2'b10, 32'hCAFE_F00D});
      if (i == 5) begin
        rsp_ready = 1;
        sb_check("t4_rsp");
      end
      tick();
    end
    rsp_ready = 0;
    chk("t4_after", {rsp_valid, cmd_ready}, 2'b01);

    // 5: back-to-back write then read, cmd_valid held high
    slave_idle();
    AW_READY = 1; W_READY = 1; AR_READY = 1;
    B_VALID = 1; R_VALID = 1; R_DATA = 32'hA5A5_0001;
    rsp_ready = 1;
    drive_cmd(1, 32'h0000_0100, 32'h1111_2222, 4'h3);
    push_exp(1, 2'b00, 0);
    push_exp(0, 2'b00, 32'hA5A5_0001);
    chk("t5_c0_ready", cmd_ready, 1);
    tick();                                       // cycle 1
    drive_cmd(0, 32'h0000_0104, 32'h0, 4'h0);
    chk("t5_c1_ready", cmd_ready, 0);
    tick();                                       // cycle 2
    chk("t5_c2_ready", cmd_ready, 0);
    tick();                                       // cycle 3: first response
    chk("t5_c3", {rsp_valid, cmd_ready}, 2'b10);
    sb_check("t5_rsp_wr");
    tick();                                       // cycle 4: second cmd taken
    chk("t5_c4_accept", {cmd_ready, rsp_valid}, 2'b10);
    tick();                                       // cycle 5
    cmd_valid = 0;
    chk("t5_c5_ar", {AR_VALID, AR_ADDR}, {1'b1, 32'h0000_0104});
    tick();                                       // cycle 6
    chk("t5_c6_r", R_READY, 1);
    tick();                                       // cycle 7
    chk("t5_c7_rsp", rsp_valid, 1);
    sb_check("t5_rsp_rd");
    tick();
    rsp_ready = 0;
    slave_idle();

    // 6: reset while AW_VALID is high
    drive_cmd(1, 32'h0000_0200, 32'h5555_AAAA, 4'hF);
    tick();
    cmd_valid = 0;
    chk("t6_aw_pending", AW_VALID, 1);
    A_RST = 1;
    tick();
    chk("t6_rst_valids", {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, rsp_valid, cmd_ready}, 0);
    A_RST = 0;
    tick();
    chk("t6_after_rst", {cmd_ready, rsp_valid}, 2'b10);

    // 7: random transactions with random slave and consumer stalls
    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom_range(0, 1));
      ra = $urandom;
      wd = $urandom;
      rd = $urandom;
      rr = 2'($urandom_range(0, 3));
      drive_cmd(wr, ra, wd, 4'($urandom_range(0, 15)));
      push_exp(wr, rr, wr ? 32'h0 : rd);
      chk("rnd_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 0;
      B_RESP = rr; R_RESP = rr; R_DATA = rd;
      done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
        if (!rsp_valid) chk("rnd_addr_hold", wr ? AW_ADDR : AR_ADDR, ra);
        AW_READY  = 1'($urandom_range(0, 1));
        W_READY   = 1'($urandom_range(0, 1));
        AR_READY  = 1'($urandom_range(0, 1));
        B_VALID   = 1'($urandom_range(0, 1));
        R_VALID   = 1'($urandom_range(0, 1));
        rsp_ready = 1'($urandom_range(0, 1));
        if (rsp_valid && rsp_ready) begin
          sb_check("rnd_rsp");
          done = 1;
        end
        tick();
      end
      if (!done) begin
        checks++;
        fails++;
        $error("FAIL rnd_timeout observed=no_response expected=response txn=%0d", t);
        A_RST = 1;
        tick();
        A_RST = 0;
        exp_q.delete();
      end
      rsp_ready = 0;
      slave_idle();
    end

    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
